// File: rtl/tia_horizontal_timing_control.sv
// TIA horizontal line sequencer: HSYNC, colour burst, HBLANK, centre flag, WSYNC RDY and scanline count.
// Define TIA_HMOVE_BLANK_EN to enable the HMOVE latch and the lrhb-extended blank.
module tia_horizontal_timing_control #(
    parameter int LINE_W = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_h_en,
    input  logic              i_shb,
    input  logic              i_shs,
    input  logic              i_rhs,
    input  logic              i_rcb,
    input  logic              i_rhb,
    input  logic              i_lrhb,
    input  logic              i_cnt,
    input  logic              i_wsync_strobe,
    input  logic              i_hmove_strobe,
    output logic              o_hsync,
    output logic              o_cburst,
    output logic              o_hblank,
    output logic              o_center,
    output logic              o_rdy,
    output logic              o_hmove_late,
    output logic [LINE_W-1:0] o_line_count
);

    logic w_shb, w_shs, w_rhs, w_rcb, w_rhb, w_cnt;
    logic w_hmove_late;
    logic w_blank_clr;

    logic              r_hsync;
    logic              r_cburst;
    logic              r_hblank;
    logic              r_center;
    logic              r_rdy;
    logic [LINE_W-1:0] r_line_count;

    assign w_shb = i_shb & i_h_en;
    assign w_shs = i_shs & i_h_en;
    assign w_rhs = i_rhs & i_h_en;
    assign w_rcb = i_rcb & i_h_en;
    assign w_rhb = i_rhb & i_h_en;
    assign w_cnt = i_cnt & i_h_en;

`ifdef TIA_HMOVE_BLANK_EN
    logic w_lrhb;
    logic r_hmove_late;

    assign w_lrhb = i_lrhb & i_h_en;

    // A fresh HMOVE on the clearing edge wins so the latch carries into the next line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hmove_late <= 1'b0;
        end else if (i_hmove_strobe) begin
            r_hmove_late <= 1'b1;
        end else if (w_lrhb) begin
            r_hmove_late <= 1'b0;
        end
    end

    assign w_hmove_late = r_hmove_late;
    assign w_blank_clr  = r_hmove_late ? w_lrhb : w_rhb;
`else
    logic w_unused;
    assign w_unused     = i_hmove_strobe ^ i_lrhb;
    assign w_hmove_late = 1'b0;
    assign w_blank_clr  = w_rhb;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hsync      <= 1'b0;
            r_cburst     <= 1'b0;
            r_hblank     <= 1'b1;
            r_center     <= 1'b0;
            r_line_count <= '0;
        end else begin
            if (w_rhs) begin
                r_hsync <= 1'b0;
            end else if (w_shs) begin
                r_hsync <= 1'b1;
            end

            if (w_rcb) begin
                r_cburst <= 1'b0;
            end else if (w_rhs) begin
                r_cburst <= 1'b1;
            end

            if (w_shb) begin
                r_hblank <= 1'b1;
            end else if (w_blank_clr) begin
                r_hblank <= 1'b0;
            end

            if (w_shb) begin
                r_center <= 1'b0;
            end else if (w_cnt) begin
                r_center <= 1'b1;
            end

            if (w_shb) begin
                r_line_count <= r_line_count + {{(LINE_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Strobes only bite while RDY is high, so a strobe on the shb edge stalls a full line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdy <= 1'b1;
        end else if (i_wsync_strobe && r_rdy) begin
            r_rdy <= 1'b0;
        end else if (w_shb) begin
            r_rdy <= 1'b1;
        end
    end

    assign o_hsync      = r_hsync;
    assign o_cburst     = r_cburst;
    assign o_hblank     = r_hblank;
    assign o_center     = r_center;
    assign o_rdy        = r_rdy;
    assign o_hmove_late = w_hmove_late;
    assign o_line_count = r_line_count;

endmodule
